symbol_vote: RTL and testbench
==============================

// Module: symbol_vote
// PURPOSE
//  Frame-level post-processor directly downstream of the network stage. Consumes per-pixel
//  symbol scores, picks each pixel's winning symbol (argmax + confidence threshold), builds a
//  per-frame histogram of winners and, at frame end, reports the dominant symbol over a
//  valid/ready handshake to the display/host side. Accumulates frame N+1 while reporting frame N.
// PARAMETERS
//  NUM_SYM   4    number of symbol score lanes
//  SCORE_W   8    width of each score
//  CNT_W     20   width of each histogram counter; holds up to 2^CNT_W-1 hits per frame
// PORTS
//  clk            in   1                 single clock, all logic rising-edge
//  reset          in   1                 asynchronous, active-low reset
//  score_valid    in   1                 sym_score valid this cycle, one pixel per beat
//  sym_score      in   NUM_SYM*SCORE_W   lane i = bits [i*SCORE_W +: SCORE_W], unsigned
//  frame_end      in   1                 1-cycle pulse; may coincide with last score beat
//  threshold      in   SCORE_W           minimum winning score for a pixel to count
//  result_valid   out  1                 frame result available
//  result_ready   in   1                 consumer accepts result when valid&&ready
//  result_sym     out  $clog2(NUM_SYM)   dominant symbol index
//  result_count   out  CNT_W             hit count of dominant symbol
//  result_none    out  1                 no pixel passed threshold in that frame
//  result_sat     out  1                 some counter saturated in that frame
//  frame_dropped  out  1                 sticky: a frame_end arrived while previous unreported
// BEHAVIOUR
//  Reset (async, reset==0): all outputs 0, counters/snapshot 0, FSM=ACCUM, pipeline valids 0.
//  Stage 1 (edge E0): register argmax of lanes (ties -> lowest index), hit = score_valid &&
//   max >= threshold (threshold sampled same cycle, unsigned compare), register frame_end.
//  Stage 2 (edge E1): if hit, live[sym] += 1, saturating at all-ones; saturation sets live
//   sat flag. If stage-1 frame_end: copy live counters (including this cycle's hit) and sat
//   flag into snapshot, clear live counters/sat to 0 (next frame starts clean), FSM->DECIDE.
//  FSM states:
//   ACCUM  : idle; stage-2 frame_end -> DECIDE (snapshot taken).
//   DECIDE : scan snapshot index 0..NUM_SYM-1, one per cycle, keep max (strictly greater
//            replaces, so ties -> lowest index); after index NUM_SYM-1 -> RESULT.
//   RESULT : result_valid=1; result_* stable until valid&&ready; then -> ACCUM, valid=0
//            the following cycle.
//  Latency: result_valid rises NUM_SYM+2 clocks after the edge sampling frame_end (6 default).
//  result_none=1 iff all snapshot counters 0; then result_sym=0, result_count=0.
//  frame_end reaching stage 2 while FSM!=ACCUM: live counters still cleared, that frame's
//   histogram discarded, frame_dropped set (cleared only by reset); current result unaffected.
//  score beats continue accumulating into live counters in every FSM state; no backpressure
//   on the input side. score_valid=0 beats never count. frame_end with no beats -> result_none.
//  result_ready while result_valid=0 is ignored.
// STRUCTURE
//  npu_pkg: NUM_SYM, SCORE_W, CNT_W defaults, FSM state encoding (ACCUM/DECIDE/RESULT),
//   lane-slice helper function.
//  Sub-module symbol_argmax: registered stage 1 (argmax, tie rule, threshold, frame_end delay).
//  Top: live/snapshot counter banks, saturation logic, FSM, output registers.
// TESTING
//  1 Frame of 10 beats, lane2=200 others 50, threshold=100, frame_end on beat 10, ready=1
//    -> after 6 clks result_valid=1, sym=2, count=10, none=0, sat=0.
//  2 Tie: lanes 0 and 3 both 180, 5 beats -> sym=0 count=5; histogram tie 3/3 sym1,sym2
//    -> sym=1 count=3.
//  3 All scores < threshold (threshold=255, scores 254) then frame_end -> none=1, sym=0, count=0.
//  4 Hold ready=0 20 cycles: outputs stable; second frame (4 hits sym3) ends meanwhile ->
//    frame_dropped=1, first result unchanged; third frame 7 hits sym1 reported correctly.
//  5 CNT_W=4, 20 hits sym1 -> count=15, sat=1; next frame 2 hits -> count=2, sat=0.
//  6 Assert reset mid-DECIDE -> outputs 0 immediately; next frame result counts only
//    post-reset beats.

Source files
------------

// File: rtl/symbol_vote_pkg.sv
// symbol_vote_pkg
//   Shared defaults, FSM state encoding and the lane-slice helper used by
//   the symbol vote post-processor.
package symbol_vote_pkg;

   localparam int NUM_SYM_D = 4;   // symbol score lanes
   localparam int SCORE_W_D = 8;   // bits per score
   localparam int CNT_W_D   = 20;  // bits per histogram counter

   typedef enum logic [1:0] {
      ST_ACCUM  = 2'd0,
      ST_DECIDE = 2'd1,
      ST_RESULT = 2'd2
   } state_e;

   // LSB position of lane idx inside a flat bus of w-bit lanes.
   function automatic int lane_lsb(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/symbol_vote_if.sv
// symbol_vote_if
//   Frame result handshake toward the display/host side.
//   valid  : result available          ready : consumer accepts on valid&&ready
//   sym    : dominant symbol index     count : hit count of that symbol
//   none   : no pixel passed threshold sat   : a counter saturated that frame
interface symbol_vote_if #(
   parameter int NUM_SYM = 4,
   parameter int CNT_W   = 20
);
   localparam int SYM_W = $clog2(NUM_SYM);

   logic             valid;
   logic             ready;
   logic [SYM_W-1:0] sym;
   logic [CNT_W-1:0] count;
   logic             none;
   logic             sat;

   modport master (output valid, sym, count, none, sat, input ready);
   modport slave  (input valid, sym, count, none, sat, output ready);
endinterface

// File: rtl/symbol_vote_argmax.sv
// symbol_vote_argmax
//   Registered first stage: per-beat argmax over the score lanes (ties go to
//   the lowest index), threshold test, and one-cycle delay of frame_end so it
//   stays aligned with the beat it may coincide with.
//   Ports: clk/reset, score_valid_i, sym_score_i, frame_end_i, threshold_i in;
//          hit_o, sym_o, fe_o registered out.
module symbol_vote_argmax
   import symbol_vote_pkg::*;
#(
   parameter int NUM_SYM = NUM_SYM_D,
   parameter int SCORE_W = SCORE_W_D,
   parameter int SYM_W   = $clog2(NUM_SYM)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       score_valid_i,
   input  logic [NUM_SYM*SCORE_W-1:0] sym_score_i,
   input  logic                       frame_end_i,
   input  logic [SCORE_W-1:0]         threshold_i,
   output logic                       hit_o,
   output logic [SYM_W-1:0]           sym_o,
   output logic                       fe_o
);

   logic [SCORE_W-1:0] max_val;
   logic [SYM_W-1:0]   max_idx;
   logic               hit_q, fe_q;
   logic [SYM_W-1:0]   sym_q;

   // Strictly-greater replacement keeps the lowest index on ties.
   always_comb begin
      max_val = sym_score_i[lane_lsb(0, SCORE_W) +: SCORE_W];
      max_idx = '0;
      for (int i = 1; i < NUM_SYM; i++) begin
         if (sym_score_i[lane_lsb(i, SCORE_W) +: SCORE_W] > max_val) begin
            max_val = sym_score_i[lane_lsb(i, SCORE_W) +: SCORE_W];
            max_idx = SYM_W'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hit_q <= 1'b0;
         sym_q <= '0;
         fe_q  <= 1'b0;
      end else begin
         hit_q <= score_valid_i && (max_val >= threshold_i);
         sym_q <= max_idx;
         fe_q  <= frame_end_i;
      end
   end

   assign hit_o = hit_q;
   assign sym_o = sym_q;
   assign fe_o  = fe_q;

endmodule

// File: rtl/symbol_vote.sv
// symbol_vote
//   Per-pixel symbol vote: stage 1 picks each beat's winner, stage 2 counts
//   winners into a live histogram. At frame end the live bank is copied to a
//   snapshot and cleared, so frame N+1 accumulates while frame N is scanned
//   (one symbol per cycle) and reported over the result handshake.
//   Ports: clk, reset (async, low), score_valid, sym_score, frame_end,
//          threshold in; frame_dropped (sticky) out; res = result handshake.
module symbol_vote
   import symbol_vote_pkg::*;
#(
   parameter int NUM_SYM = NUM_SYM_D,
   parameter int SCORE_W = SCORE_W_D,
   parameter int CNT_W   = CNT_W_D
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       score_valid,
   input  logic [NUM_SYM*SCORE_W-1:0] sym_score,
   input  logic                       frame_end,
   input  logic [SCORE_W-1:0]         threshold,
   output logic                       frame_dropped,
   symbol_vote_if.master              res
);

   localparam int SYM_W = $clog2(NUM_SYM);
   typedef logic [NUM_SYM-1:0][CNT_W-1:0] bank_t;

   logic             s1_hit, s1_fe;
   logic [SYM_W-1:0] s1_sym;

   bank_t            live_q, live_d, live_inc, snap_q, snap_d;
   logic             lsat_q, lsat_d, lsat_inc, ssat_q, ssat_d;
   state_e           state_q, state_d;
   logic [SYM_W-1:0] scan_q, scan_d, bsym_q, bsym_d, osym_q, osym_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d, ocnt_q, ocnt_d;
   logic             vld_q, vld_d, onone_q, onone_d, osat_q, osat_d;
   logic             drop_q, drop_d;

   symbol_vote_argmax #(.NUM_SYM(NUM_SYM), .SCORE_W(SCORE_W)) u_argmax (
      .clk           (clk),
      .reset         (reset),
      .score_valid_i (score_valid),
      .sym_score_i   (sym_score),
      .frame_end_i   (frame_end),
      .threshold_i   (threshold),
      .hit_o         (s1_hit),
      .sym_o         (s1_sym),
      .fe_o          (s1_fe)
   );

   // Live bank including this cycle's hit; an all-ones counter holds and
   // flags saturation instead of wrapping.
   always_comb begin
      live_inc = live_q;
      lsat_inc = lsat_q;
      if (s1_hit) begin
         if (&live_q[s1_sym]) lsat_inc = 1'b1;
         else                 live_inc[s1_sym] = live_q[s1_sym] + CNT_W'(1);
      end
   end

   always_comb begin
      state_d = state_q;
      live_d  = live_inc;
      lsat_d  = lsat_inc;
      snap_d  = snap_q;
      ssat_d  = ssat_q;
      drop_d  = drop_q;
      scan_d  = scan_q;
      bsym_d  = bsym_q;
      bcnt_d  = bcnt_q;
      vld_d   = vld_q;
      osym_d  = osym_q;
      ocnt_d  = ocnt_q;
      onone_d = onone_q;
      osat_d  = osat_q;

      // Frame boundary always restarts the live bank; the finished frame is
      // only kept if the previous result has already been handed off.
      if (s1_fe) begin
         live_d = '0;
         lsat_d = 1'b0;
         if (state_q == ST_ACCUM) begin
            snap_d = live_inc;
            ssat_d = lsat_inc;
         end else begin
            drop_d = 1'b1;
         end
      end

      case (state_q)
         ST_ACCUM: begin
            if (s1_fe) begin
               state_d = ST_DECIDE;
               scan_d  = '0;
               bsym_d  = '0;
               bcnt_d  = '0;
            end
         end
         ST_DECIDE: begin
            if (snap_q[scan_q] > bcnt_q) begin
               bsym_d = scan_q;
               bcnt_d = snap_q[scan_q];
            end
            if (scan_q == SYM_W'(NUM_SYM - 1)) state_d = ST_RESULT;
            else                               scan_d  = scan_q + SYM_W'(1);
         end
         ST_RESULT: begin
            // First RESULT cycle loads the output registers; they then hold
            // until the consumer takes them.
            if (!vld_q) begin
               vld_d   = 1'b1;
               osym_d  = bsym_q;
               ocnt_d  = bcnt_q;
               onone_d = (bcnt_q == '0);
               osat_d  = ssat_q;
            end else if (res.ready) begin
               vld_d   = 1'b0;
               state_d = ST_ACCUM;
            end
         end
         default: state_d = ST_ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_ACCUM;
         live_q  <= '0;
         lsat_q  <= 1'b0;
         snap_q  <= '0;
         ssat_q  <= 1'b0;
         drop_q  <= 1'b0;
         scan_q  <= '0;
         bsym_q  <= '0;
         bcnt_q  <= '0;
         vld_q   <= 1'b0;
         osym_q  <= '0;
         ocnt_q  <= '0;
         onone_q <= 1'b0;
         osat_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         live_q  <= live_d;
         lsat_q  <= lsat_d;
         snap_q  <= snap_d;
         ssat_q  <= ssat_d;
         drop_q  <= drop_d;
         scan_q  <= scan_d;
         bsym_q  <= bsym_d;
         bcnt_q  <= bcnt_d;
         vld_q   <= vld_d;
         osym_q  <= osym_d;
         ocnt_q  <= ocnt_d;
         onone_q <= onone_d;
         osat_q  <= osat_d;
      end
   end

   assign res.valid     = vld_q;
   assign res.sym       = osym_q;
   assign res.count     = ocnt_q;
   assign res.none      = onone_q;
   assign res.sat       = osat_q;
   assign frame_dropped = drop_q;

endmodule

// File: tb/tb_symbol_vote.sv
module tb_symbol_vote;

   typedef struct {
      int sym;
      int cnt;
      bit none;
      bit sat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sv, fe, rdy;
   logic [31:0] score;
   logic [7:0]  thr;
   logic        drop_b, drop_s;

   int chks = 0;
   int errs = 0;

   always #5 clk = ~clk;

   // Same stimulus into a wide-counter and a 4-bit-counter instance.
   symbol_vote_if #(.NUM_SYM(4), .CNT_W(20)) rb();
   symbol_vote_if #(.NUM_SYM(4), .CNT_W(4))  rs();
   assign rb.ready = rdy;
   assign rs.ready = rdy;

   symbol_vote #(.NUM_SYM(4), .SCORE_W(8), .CNT_W(20)) u_big (
      .clk(clk), .reset(rst_n), .score_valid(sv), .sym_score(score),
      .frame_end(fe), .threshold(thr), .frame_dropped(drop_b), .res(rb));
   symbol_vote #(.NUM_SYM(4), .SCORE_W(8), .CNT_W(4)) u_small (
      .clk(clk), .reset(rst_n), .score_valid(sv), .sym_score(score),
      .frame_end(fe), .threshold(thr), .frame_dropped(drop_s), .res(rs));

   task automatic chk(input string n, input logic [31:0] act, input int exp);
      chks++;
      if (act !== 32'(exp)) begin
         errs++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", n, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic exp_t calc(input int h[4], input int cw);
      exp_t r;
      int   cap, c;
      cap = (1 << cw) - 1;
      r.sym = 0; r.cnt = 0; r.sat = 0;
      for (int i = 0; i < 4; i++) begin
         c = (h[i] > cap) ? cap : h[i];
         if (h[i] > cap) r.sat = 1;
         if (c > r.cnt) begin r.cnt = c; r.sym = i; end
      end
      r.none = (r.cnt == 0);
      return r;
   endfunction

   int   hist[4], closed[4];
   bit   closing, busy, ev, edrop;
   int   cyc, valid_at;
   exp_t er[2];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist = '{default:0}; closing = 0; busy = 0; ev = 0; edrop = 0;
         cyc = 0; valid_at = 0;
      end else begin
         int m, w;
         cyc++;
         // A frame closed last edge is kept only if no result is pending.
         if (closing) begin
            if (busy) edrop = 1;
            else begin
               busy = 1;
               valid_at = cyc + 5;
               er[0] = calc(closed, 20);
               er[1] = calc(closed, 4);
            end
         end
         if (ev && rdy) begin ev = 0; busy = 0; end
         else if (busy && !ev && cyc == valid_at) ev = 1;
         closing = 0;
         if (sv) begin
            m = score[7:0]; w = 0;
            for (int i = 1; i < 4; i++)
               if (int'(score[i*8 +: 8]) > m) begin m = score[i*8 +: 8]; w = i; end
            if (m >= int'(thr)) hist[w]++;
         end
         if (fe) begin closed = hist; closing = 1; hist = '{default:0}; end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      chk("valid_big", rb.valid, ev);
      chk("valid_small", rs.valid, ev);
      chk("dropped_big", drop_b, edrop);
      chk("dropped_small", drop_s, edrop);
      if (ev) begin
         chk("sym_big", rb.sym, er[0].sym);
         chk("count_big", rb.count, er[0].cnt);
         chk("none_big", rb.none, er[0].none);
         chk("sat_big", rb.sat, er[0].sat);
         chk("sym_small", rs.sym, er[1].sym);
         chk("count_small", rs.count, er[1].cnt);
         chk("none_small", rs.none, er[1].none);
         chk("sat_small", rs.sat, er[1].sat);
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      sv = 0; fe = 0; score = '0;
   endtask

   task automatic hits(input int s, input int n, input bit fe_last);
      for (int k = 0; k < n; k++) begin
         sv = 1;
         score = {4{8'd50}};
         score[s*8 +: 8] = 8'd200;
         fe = fe_last && (k == n - 1);
         step(1);
      end
      idle();
   endtask

   task automatic wait_valid(input string n, input int budget);
      int k = 0;
      while (!rb.valid && k < budget) begin step(1); k++; end
      if (!rb.valid) begin
         chks++; errs++;
         $display("FAIL %s timeout actual=0 expected=1", n);
      end
   endtask

   initial begin
      idle(); rdy = 1; thr = 8'd100;
      step(2);
      chk("rst_valid", rb.valid, 0);
      chk("rst_count", rb.count, 0);
      chk("rst_drop", drop_b, 0);
      #3 rst_n = 1;
      step(1);

      // 1: ten beats, lane 2 wins, frame_end on the last beat
      for (int b = 1; b <= 10; b++) begin
         sv = 1; score = {8'd50, 8'd200, 8'd50, 8'd50}; fe = (b == 10);
         step(1);
      end
      idle();
      step(5);
      chk("t1_latency_early", rb.valid, 0);
      step(1);
      chk("t1_valid", rb.valid, 1);
      chk("t1_sym", rb.sym, 2);
      chk("t1_count", rb.count, 10);
      chk("t1_none", rb.none, 0);
      chk("t1_sat", rb.sat, 0);
      step(2);

      // 2: lane tie, then histogram tie
      for (int b = 0; b < 5; b++) begin
         sv = 1; score = {8'd180, 8'd20, 8'd20, 8'd180}; fe = (b == 4);
         step(1);
      end
      idle();
      wait_valid("t2a", 20);
      chk("t2_lane_tie_sym", rb.sym, 0);
      chk("t2_lane_tie_count", rb.count, 5);
      step(1);
      hits(1, 3, 0);
      hits(2, 3, 1);
      wait_valid("t2b", 20);
      chk("t2_hist_tie_sym", rb.sym, 1);
      chk("t2_hist_tie_count", rb.count, 3);
      step(1);

      // 3: nothing passes threshold; invalid beat must not count
      thr = 8'd255;
      for (int b = 0; b < 4; b++) begin sv = 1; score = {4{8'd254}}; fe = 0; step(1); end
      sv = 0; score = {4{8'd255}}; fe = 1; step(1);
      idle();
      wait_valid("t3", 20);
      chk("t3_none", rb.none, 1);
      chk("t3_sym", rb.sym, 0);
      chk("t3_count", rb.count, 0);
      thr = 8'd100;
      step(1);

      // 4: consumer stalls; second frame is dropped
      rdy = 0;
      hits(0, 5, 1);
      wait_valid("t4a", 20);
      hits(3, 4, 1);
      step(16);
      chk("t4_hold_sym", rb.sym, 0);
      chk("t4_hold_count", rb.count, 5);
      chk("t4_dropped", drop_b, 1);
      rdy = 1;
      step(1);
      hits(1, 7, 1);
      wait_valid("t4c", 20);
      chk("t4_third_sym", rb.sym, 1);
      chk("t4_third_count", rb.count, 7);
      step(1);

      // 5: saturation in the 4-bit instance
      hits(1, 20, 1);
      wait_valid("t5a", 20);
      chk("t5_small_count", rs.count, 15);
      chk("t5_small_sat", rs.sat, 1);
      chk("t5_big_count", rb.count, 20);
      chk("t5_big_sat", rb.sat, 0);
      step(1);
      hits(1, 2, 1);
      wait_valid("t5b", 20);
      chk("t5_next_count", rs.count, 2);
      chk("t5_next_sat", rs.sat, 0);
      step(1);

      // 6: reset during DECIDE discards live beats
      hits(2, 3, 1);
      hits(0, 3, 0);
      #2 rst_n = 0;
      #1;
      chk("t6_rst_valid", rb.valid, 0);
      chk("t6_rst_drop", drop_b, 0);
      chk("t6_rst_count", rb.count, 0);
      #2 rst_n = 1;
      step(1);
      hits(3, 2, 1);
      wait_valid("t6", 20);
      chk("t6_sym", rb.sym, 3);
      chk("t6_count", rb.count, 2);
      chk("t6_none", rb.none, 0);
      step(1);

      // random traffic
      for (int c = 0; c < 4000; c++) begin
         int bias;
         bias = (c / 250) % 4;
         sv = ($urandom_range(0, 3) != 0);
         score = $urandom;
         if ($urandom_range(0, 1) == 1) score[bias*8 +: 8] = 8'd250;
         if ($urandom_range(0, 99) < 3) score = {4{8'($urandom_range(0, 255))}};
         fe = (c < 2000) ? ($urandom_range(0, 11) == 0) : ($urandom_range(0, 39) == 0);
         rdy = ($urandom_range(0, 2) != 0);
         if ($urandom_range(0, 199) == 0) thr = 8'($urandom_range(0, 200));
         step(1);
      end
      idle(); rdy = 1;
      step(30);
      $display("CHECKS %0d ERRORS %0d", chks, errs);
      $finish;
   end

endmodule
